y86_regfile: RTL
================

# y86_regfile

Architectural register file at the far end of the W pipeline register in the Y86 pipeline. It consumes the W-stage writeback bundle and commits valE/valM to the 15 program registers. It serves the two combinational decode read ports. It tracks a sticky program status and a retired-instruction counter.

## Interface
- NREGS, 15, number of architectural registers (IDs 0..14); ID 4'hF is RNONE
- W, 64, register data width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- W_stat  in  2  status of instruction in W (AOK=0, HLT=1, ADR=2, INS=3)
- W_icode  in  4  icode in W (NOP=1 marks a bubble)
- W_dstE  in  4  E-port destination ID, RNONE = no write
- W_valE  in  W  E-port write data
- W_dstM  in  4  M-port destination ID, RNONE = no write
- W_valM  in  W  M-port write data
- d_srcA  in  4  read port A ID
- d_srcB  in  4  read port B ID
- d_rvalA  out  W  read data A
- d_rvalB  out  W  read data B
- prog_stat  out  2  sticky program status
- halted  out  1  high once prog_stat != AOK
- retired  out  64  count of committed non-bubble instructions

## Operation
- Commit enable: `commit = !halted && W_stat == AOK`.
- E write: on a clk edge with commit and W_dstE != RNONE, reg[W_dstE] <= W_valE.
- M write: on a clk edge with commit and W_dstM != RNONE, reg[W_dstM] <= W_valM.
- Same destination on both ports (dstE == dstM != RNONE): the M port wins.
- Reads are combinational: d_rvalX = reg[d_srcX]. A read of RNONE returns 0.
- Status capture:
  - When `!halted && W_stat != AOK`, prog_stat <= W_stat and halted <= 1 on that edge.
  - No register write occurs on that edge.
  - halted and prog_stat then hold until rst.
- States: RUN (halted=0) and STOP (halted=1). RUN→STOP on a non-AOK W_stat. STOP→RUN only via rst.
- Counter:
  - retired increments by 1 on each edge with commit and W_icode != NOP.
  - It wraps modulo 2^64.
  - It is frozen in STOP.
- The instruction carrying HLT/ADR/INS is not counted.

## Timing
- Write latency: data written at edge N is visible on the read ports from edge N onward, i.e. to the cycle after the W bundle is presented.
- Read latency: 0 cycles (combinational from d_srcX and register state).
- Reset: asynchronous assertion immediately clears all registers to 0, prog_stat=AOK, halted=0, retired=0. The read ports therefore return 0.
- Reset mid-operation: any write or status capture on the same edge as rst is discarded. Release is synchronous to the next clk edge.
- Simultaneous non-AOK status and valid dst: the status is captured and the writes are suppressed.
- Both dst = RNONE: no write. retired still counts if the instruction is AOK and not a bubble.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: a read port whose ID matches a write being committed in the same cycle returns that write's data (M over E on a double match). Write-to-read latency becomes 0 cycles. RNONE still reads 0.
- Undefined: reads return stored state only. The pipeline's forwarding logic covers W hazards.

## Structure
- Shared package y86_pkg holds:
  - RNONE = 4'hF.
  - Stat codes AOK/HLT/ADR/INS.
  - IC_NOP = 4'h1 and IC_HALT = 4'h0.
  - Register-ID names (RRSP = 4'h4 etc.).
- One natural sub-module, y86_stat_track, holds the halted/prog_stat sticky flops and the commit-enable output. The register array, read muxes and counter stay in y86_regfile.

## Test plan
- Reset, then read all IDs 0..14 and RNONE → all d_rval = 0, prog_stat=AOK, halted=0, retired=0.
- Present W_stat=AOK, W_icode=6, dstE=3, valE=64'h1234, dstM=RNONE, then d_srcA=3 next cycle → d_rvalA=64'h1234, retired=1.
- Present dstE=dstM=4 with valE=64'hAAAA and valM=64'hBBBB → reg4=64'hBBBB.
- Present W_stat=ADR with dstE=2, valE=5, then an AOK write to reg 1 → reg2 and reg1 unchanged, prog_stat=ADR, halted=1, retired frozen.
- Run bubbles (W_icode=1, AOK) for 3 cycles → retired unchanged. Assert rst mid-stream after writes → registers, retired and status cleared asynchronously.
- With REGFILE_BYPASS_EN: write dstM=7, valM=64'h77 while d_srcB=7 in the same cycle → d_rvalB=64'h77 before the edge. Without the macro → d_rvalB shows the old value.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: register IDs, status codes, icodes and tracker states.
package y86_pkg;

    localparam int NREGS = 15;
    localparam int W     = 64;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] RRAX = 4'h0;
    localparam logic [3:0] RRCX = 4'h1;
    localparam logic [3:0] RRDX = 4'h2;
    localparam logic [3:0] RRBX = 4'h3;
    localparam logic [3:0] RRSP = 4'h4;
    localparam logic [3:0] RRBP = 4'h5;
    localparam logic [3:0] RRSI = 4'h6;
    localparam logic [3:0] RRDI = 4'h7;
    localparam logic [3:0] RR8  = 4'h8;
    localparam logic [3:0] RR9  = 4'h9;
    localparam logic [3:0] RR10 = 4'hA;
    localparam logic [3:0] RR11 = 4'hB;
    localparam logic [3:0] RR12 = 4'hC;
    localparam logic [3:0] RR13 = 4'hD;
    localparam logic [3:0] RR14 = 4'hE;

    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_NOP  = 4'h1;

    typedef enum logic [1:0] {
        AOK = 2'd0,
        HLT = 2'd1,
        ADR = 2'd2,
        INS = 2'd3
    } stat_e;

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } trk_state_e;

    // True when the ID names a real architectural register.
    function automatic logic is_reg(input logic [3:0] id);
        return (id != RNONE);
    endfunction

endpackage

// File: rtl/y86_regfile_if.sv
// W-stage writeback bundle, decode read ports and status outputs of the register file.
interface y86_regfile_if #(parameter int W = 64);
    logic [1:0]   W_stat;
    logic [3:0]   W_icode;
    logic [3:0]   W_dstE;
    logic [W-1:0] W_valE;
    logic [3:0]   W_dstM;
    logic [W-1:0] W_valM;
    logic [3:0]   d_srcA;
    logic [3:0]   d_srcB;
    logic [W-1:0] d_rvalA;
    logic [W-1:0] d_rvalB;
    logic [1:0]   prog_stat;
    logic         halted;
    logic [63:0]  retired;

    modport master (
        output W_stat, W_icode, W_dstE, W_valE, W_dstM, W_valM, d_srcA, d_srcB,
        input  d_rvalA, d_rvalB, prog_stat, halted, retired
    );

    modport slave (
        input  W_stat, W_icode, W_dstE, W_valE, W_dstM, W_valM, d_srcA, d_srcB,
        output d_rvalA, d_rvalB, prog_stat, halted, retired
    );
endinterface

// File: rtl/y86_stat_track.sv
// Sticky program status tracker: RUN until the first non-AOK instruction
// reaches W, then STOP until reset. Produces the commit enable.
module y86_stat_track
    import y86_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] w_stat,
    output logic [1:0] prog_stat,
    output logic       halted,
    output logic       commit
);

    trk_state_e state_r;
    stat_e      prog_stat_r;
    logic       commit_s;

    // RUN/STOP state and the captured status of the faulting instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= RUN;
            prog_stat_r <= AOK;
        end else begin
            case (state_r)
                RUN: begin
                    if (w_stat != AOK) begin
                        state_r     <= STOP;
                        prog_stat_r <= stat_e'(w_stat);
                    end else begin
                        state_r     <= RUN;
                    end
                end
                STOP: begin
                    state_r <= STOP;
                end
                default: begin
                    state_r     <= STOP;
                    prog_stat_r <= INS;
                end
            endcase
        end
    end

    // Commit only healthy instructions while still running.
    always_comb begin
        commit_s = 1'b0;
        if ((state_r == RUN) && (w_stat == AOK)) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    assign prog_stat = prog_stat_r;
    assign halted    = (state_r == STOP);
    assign commit    = commit_s;

endmodule

// File: rtl/y86_regfile.sv
// Y86 architectural register file: commits the W-stage bundle, serves two
// combinational decode read ports, tracks sticky status and retired count.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module y86_regfile
    import y86_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    y86_regfile_if.slave  rf
);

    logic [W-1:0] regs_r [NREGS];
    logic [63:0]  retired_r;
    logic         commit_s;
    logic         halted_s;
    logic [1:0]   prog_stat_s;
    logic [W-1:0] rval_a_s;
    logic [W-1:0] rval_b_s;

    y86_stat_track u_stat (
        .clk       (clk),
        .rst       (rst),
        .w_stat    (rf.W_stat),
        .prog_stat (prog_stat_s),
        .halted    (halted_s),
        .commit    (commit_s)
    );

    // Register array writes; M is applied after E so it wins on a shared destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (commit_s) begin
            if (is_reg(rf.W_dstE)) begin
                regs_r[rf.W_dstE] <= rf.W_valE;
            end
            if (is_reg(rf.W_dstM)) begin
                regs_r[rf.W_dstM] <= rf.W_valM;
            end
        end
    end

    // Retired-instruction counter: committed non-bubbles only, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_r <= 64'd0;
        end else if (commit_s && (rf.W_icode != IC_NOP)) begin
            retired_r <= retired_r + 64'd1;
        end
    end

    // Read port A: RNONE reads zero; optional same-cycle forwarding of W writes.
    always_comb begin
        rval_a_s = '0;
        if (!is_reg(rf.d_srcA)) begin
            rval_a_s = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (commit_s && (rf.W_dstM == rf.d_srcA)) begin
            rval_a_s = rf.W_valM;
        end else if (commit_s && (rf.W_dstE == rf.d_srcA)) begin
            rval_a_s = rf.W_valE;
`endif
        end else begin
            rval_a_s = regs_r[rf.d_srcA];
        end
    end

    // Read port B: same selection rules as port A.
    always_comb begin
        rval_b_s = '0;
        if (!is_reg(rf.d_srcB)) begin
            rval_b_s = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (commit_s && (rf.W_dstM == rf.d_srcB)) begin
            rval_b_s = rf.W_valM;
        end else if (commit_s && (rf.W_dstE == rf.d_srcB)) begin
            rval_b_s = rf.W_valE;
`endif
        end else begin
            rval_b_s = regs_r[rf.d_srcB];
        end
    end

    assign rf.d_rvalA   = rval_a_s;
    assign rf.d_rvalB   = rval_b_s;
    assign rf.prog_stat = prog_stat_s;
    assign rf.halted    = halted_s;
    assign rf.retired   = retired_r;

endmodule
